// File: rtl/ddr4_cmd_issuer.sv
// ddr4_cmd_issuer: last stage before the DDR4 pins. Tracks per-bank open/closed
// state with activation/precharge countdowns, accepts scheduler commands over
// valid/ready, drives registered command/address/data pins and returns read
// data CAS_LATENCY cycles after the read command reaches the pins.
module ddr4_cmd_issuer #(
    parameter int unsigned CAS_LATENCY        = 22,
    parameter int unsigned ACTIVATION_LATENCY = 8,
    parameter int unsigned PRECHARGE_LATENCY  = 5,
    parameter int unsigned ROW_BITS           = 8,
    parameter int unsigned COL_BITS           = 4,
    parameter int unsigned BANK_GROUPS        = 4,
    parameter int unsigned BANKS_PER_GROUP    = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_in,
    input  logic                                    cmd_valid_in,
    output logic                                    cmd_ready_out,
    input  logic [2:0]                              cmd_in,
    input  logic [$clog2(BANK_GROUPS)-1:0]          bank_group_in,
    input  logic [$clog2(BANKS_PER_GROUP)-1:0]      bank_in,
    input  logic [ROW_BITS-1:0]                     row_in,
    input  logic [COL_BITS-1:0]                     col_in,
    input  logic [63:0]                             wdata_in,
    output logic                                    act_out,
    output logic [1:0]                              dram_cmd_out,
    output logic [16:0]                             dram_addr_out,
    output logic [$clog2(BANK_GROUPS)-1:0]          bg_out,
    output logic [$clog2(BANKS_PER_GROUP)-1:0]      ba_out,
    output logic [63:0]                             dq_out,
    output logic                                    dq_oe_out,
    input  logic [63:0]                             dq_in,
    output logic                                    rdata_valid_out,
    output logic [63:0]                             rdata_out,
    output logic [BANK_GROUPS*BANKS_PER_GROUP-1:0]  bank_open_out,
    output logic                                    err_out
);

    localparam int unsigned NBANKS  = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int unsigned IDX_W   = $clog2(NBANKS);
    localparam int unsigned BG_W    = $clog2(BANK_GROUPS);
    localparam int unsigned BA_W    = $clog2(BANKS_PER_GROUP);
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned MAX_LAT = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                                      ACTIVATION_LATENCY : PRECHARGE_LATENCY;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int unsigned INF_W   = $clog2(CAS_LATENCY + 3);

    localparam logic [2:0] CMD_RD  = 3'd0;
    localparam logic [2:0] CMD_WR  = 3'd1;
    localparam logic [2:0] CMD_ACT = 3'd2;
    localparam logic [2:0] CMD_PRE = 3'd3;

    localparam logic [1:0] PIN_NOP = 2'd0;
    localparam logic [1:0] PIN_RD  = 2'd1;
    localparam logic [1:0] PIN_WR  = 2'd2;
    localparam logic [1:0] PIN_PRE = 2'd3;

    typedef enum logic [1:0] {
        BANK_IDLE,
        BANK_ACTIVATING,
        BANK_OPEN,
        BANK_PRECHARGING
    } bank_state_e;

    bank_state_e           state_q [NBANKS];
    bank_state_e           state_d [NBANKS];
    logic [CNT_W-1:0]      cnt_q   [NBANKS];
    logic [CNT_W-1:0]      cnt_d   [NBANKS];
    logic [ROW_BITS-1:0]   row_q   [NBANKS];
    logic [ROW_BITS-1:0]   row_d   [NBANKS];

    logic [CAS_LATENCY:0]  rd_pipe_q, rd_pipe_d;
    logic [INF_W-1:0]      inflight_q, inflight_d;

    logic                  act_q, act_d;
    logic [1:0]            dram_cmd_q, dram_cmd_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BG_W-1:0]       bg_q, bg_d;
    logic [BA_W-1:0]       ba_q, ba_d;
    logic [63:0]           dq_q, dq_d;
    logic                  dq_oe_q, dq_oe_d;
    logic                  err_q, err_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic [63:0]           rdata_q, rdata_d;
    logic [NBANKS-1:0]     bank_open_q, bank_open_d;

    logic [IDX_W-1:0]      bank_idx;
    bank_state_e           cur_state;
    logic                  row_hit;
    logic                  fire;
    logic                  rd_issue;

    assign bank_idx = IDX_W'(bank_group_in) * IDX_W'(BANKS_PER_GROUP) + IDX_W'(bank_in);

    // State register: bank FSMs, read pipe and all registered outputs
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= '{default: BANK_IDLE};
            cnt_q         <= '{default: '0};
            row_q         <= '{default: '0};
            rd_pipe_q     <= '0;
            inflight_q    <= '0;
            act_q         <= 1'b0;
            dram_cmd_q    <= PIN_NOP;
            addr_q        <= '0;
            bg_q          <= '0;
            ba_q          <= '0;
            dq_q          <= '0;
            dq_oe_q       <= 1'b0;
            err_q         <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            bank_open_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            rd_pipe_q     <= rd_pipe_d;
            inflight_q    <= inflight_d;
            act_q         <= act_d;
            dram_cmd_q    <= dram_cmd_d;
            addr_q        <= addr_d;
            bg_q          <= bg_d;
            ba_q          <= ba_d;
            dq_q          <= dq_d;
            dq_oe_q       <= dq_oe_d;
            err_q         <= err_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
            bank_open_q   <= bank_open_d;
        end
    end

    // Acceptance decision, bank FSM next state, pin command and read-return logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        row_d         = row_q;
        act_d         = 1'b0;
        dram_cmd_d    = PIN_NOP;
        addr_d        = '0;
        bg_d          = bg_q;
        ba_d          = ba_q;
        dq_d          = dq_q;
        dq_oe_d       = 1'b0;
        err_d         = 1'b0;
        rd_issue      = 1'b0;
        cmd_ready_out = 1'b1;
        cur_state     = state_q[bank_idx];
        row_hit       = (row_q[bank_idx] == row_in);

        // Countdowns: the transition lands on the cycle the counter would hit zero
        for (int i = 0; i < NBANKS; i++) begin
            if (state_q[i] == BANK_ACTIVATING) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
                if (cnt_q[i] == CNT_W'(1)) state_d[i] = BANK_OPEN;
            end else if (state_q[i] == BANK_PRECHARGING) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
                if (cnt_q[i] == CNT_W'(1)) state_d[i] = BANK_IDLE;
            end
        end

        // Stall only while the target bank is mid-transition (or bus turnaround for WR)
        case (cmd_in)
            CMD_RD:  cmd_ready_out = (cur_state != BANK_ACTIVATING);
            CMD_WR:  cmd_ready_out = (cur_state != BANK_ACTIVATING) && (inflight_q == '0);
            CMD_ACT: cmd_ready_out = (cur_state != BANK_PRECHARGING);
            CMD_PRE: cmd_ready_out = (cur_state != BANK_ACTIVATING);
            default: cmd_ready_out = 1'b1;
        endcase

        fire = cmd_valid_in && cmd_ready_out;

        if (fire) begin
            case (cmd_in)
                CMD_RD, CMD_WR: begin
                    if ((cur_state == BANK_OPEN) && row_hit) begin
                        dram_cmd_d = (cmd_in == CMD_RD) ? PIN_RD : PIN_WR;
                        addr_d     = ADDR_W'(col_in);
                        bg_d       = bank_group_in;
                        ba_d       = bank_in;
                        if (cmd_in == CMD_WR) begin
                            dq_d    = wdata_in;
                            dq_oe_d = 1'b1;
                        end else begin
                            rd_issue = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_ACT: begin
                    if (cur_state == BANK_IDLE) begin
                        act_d           = 1'b1;
                        addr_d          = ADDR_W'(row_in);
                        bg_d            = bank_group_in;
                        ba_d            = bank_in;
                        row_d[bank_idx] = row_in;
                        cnt_d[bank_idx] = CNT_W'(ACTIVATION_LATENCY - 1);
                        state_d[bank_idx] = (ACTIVATION_LATENCY > 1) ? BANK_ACTIVATING : BANK_OPEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_PRE: begin
                    // PRE to a closed/closing bank is a silent no-op
                    if (cur_state == BANK_OPEN) begin
                        dram_cmd_d      = PIN_PRE;
                        bg_d            = bank_group_in;
                        ba_d            = bank_in;
                        cnt_d[bank_idx] = CNT_W'(PRECHARGE_LATENCY - 1);
                        state_d[bank_idx] = (PRECHARGE_LATENCY > 1) ? BANK_PRECHARGING : BANK_IDLE;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end

        for (int i = 0; i < NBANKS; i++) begin
            bank_open_d[i] = (state_d[i] == BANK_OPEN);
        end

        // Read return: the pipe tail marks the cycle dq_in carries the data
        rd_pipe_d     = {rd_pipe_q[CAS_LATENCY-1:0], rd_issue};
        rdata_valid_d = rd_pipe_q[CAS_LATENCY];
        rdata_d       = rd_pipe_q[CAS_LATENCY] ? dq_in : rdata_q;

        // A read stays in flight until its rdata_valid_out cycle has passed
        inflight_d = inflight_q;
        if (rd_issue && !rdata_valid_q) begin
            inflight_d = inflight_q + INF_W'(1);
        end else if (!rd_issue && rdata_valid_q) begin
            inflight_d = inflight_q - INF_W'(1);
        end
    end

    assign act_out         = act_q;
    assign dram_cmd_out    = dram_cmd_q;
    assign dram_addr_out   = addr_q;
    assign bg_out          = bg_q;
    assign ba_out          = ba_q;
    assign dq_out          = dq_q;
    assign dq_oe_out       = dq_oe_q;
    assign err_out         = err_q;
    assign rdata_valid_out = rdata_valid_q;
    assign rdata_out       = rdata_q;
    assign bank_open_out   = bank_open_q;

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// Bench for ddr4_cmd_issuer: a vector table, hand-written timing sequences and a
// randomized run against a timestamp-based bank/read model.
module tb_ddr4_cmd_issuer;

    localparam int CL = 22;
    localparam int AL = 8;
    localparam int PL = 5;

    logic        clk;
    logic        rst_in;
    logic        cmd_valid_in;
    logic        cmd_ready_out;
    logic [2:0]  cmd_in;
    logic [1:0]  bank_group_in;
    logic [1:0]  bank_in;
    logic [7:0]  row_in;
    logic [3:0]  col_in;
    logic [63:0] wdata_in;
    logic        act_out;
    logic [1:0]  dram_cmd_out;
    logic [16:0] dram_addr_out;
    logic [1:0]  bg_out;
    logic [1:0]  ba_out;
    logic [63:0] dq_out;
    logic        dq_oe_out;
    logic [63:0] dq_in;
    logic        rdata_valid_out;
    logic [63:0] rdata_out;
    logic [15:0] bank_open_out;
    logic        err_out;

    ddr4_cmd_issuer dut (
        .clk(clk), .rst_in(rst_in),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out), .cmd_in(cmd_in),
        .bank_group_in(bank_group_in), .bank_in(bank_in), .row_in(row_in),
        .col_in(col_in), .wdata_in(wdata_in),
        .act_out(act_out), .dram_cmd_out(dram_cmd_out), .dram_addr_out(dram_addr_out),
        .bg_out(bg_out), .ba_out(ba_out), .dq_out(dq_out), .dq_oe_out(dq_oe_out),
        .dq_in(dq_in), .rdata_valid_out(rdata_valid_out), .rdata_out(rdata_out),
        .bank_open_out(bank_open_out), .err_out(err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic drive(input bit v, input logic [2:0] c, input int bank,
                         input logic [7:0] row, input logic [3:0] col, input logic [63:0] wd);
        cmd_valid_in  = v;
        cmd_in        = c;
        bank_group_in = 2'(bank / 4);
        bank_in       = 2'(bank % 4);
        row_in        = row;
        col_in        = col;
        wdata_in      = wd;
    endtask

    task automatic idle();
        cmd_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_in = 1'b1;
        idle();
        @(posedge clk); #1;
        rst_in = 1'b0;
    endtask

    // Vector record: inputs for one cycle, ready that cycle, pins the cycle after
    typedef struct {
        bit          v;
        logic [2:0]  cmd;
        int          bank;
        logic [7:0]  row;
        logic [3:0]  col;
        bit          e_rdy;
        bit          e_act;
        logic [1:0]  e_cmd;
        logic [16:0] e_addr;
        bit          e_err;
    } vec_t;

    function automatic vec_t mk(bit v, logic [2:0] cmd, int bank, logic [7:0] row, logic [3:0] col,
                                bit e_rdy, bit e_act, logic [1:0] e_cmd, logic [16:0] e_addr, bit e_err);
        vec_t r;
        r.v = v; r.cmd = cmd; r.bank = bank; r.row = row; r.col = col;
        r.e_rdy = e_rdy; r.e_act = e_act; r.e_cmd = e_cmd; r.e_addr = e_addr; r.e_err = e_err;
        return r;
    endfunction

    vec_t tbl [18];

    // Reference model: bank state derived from the cycle of its last ACT/PRE
    bit          m_isact [16];
    int          m_t     [16];
    logic [7:0]  m_row   [16];
    int          rd_q    [$];
    logic [63:0] dq_hist [128];

    function automatic int bstate(int b, int c);
        // 0 idle, 1 activating, 2 open, 3 precharging
        if (m_isact[b]) return (c < m_t[b] + AL) ? 1 : 2;
        return (c < m_t[b] + PL) ? 3 : 0;
    endfunction

    initial begin
        bit          acc;
        bit          seen;
        bit          v;
        logic [2:0]  mc;
        int          bank, st, r;
        logic [7:0]  row;
        logic [3:0]  col;
        logic [63:0] wd;
        bit          mrdy, infl, e_act, e_err, e_oe, e_rv;
        logic [1:0]  e_cmd, e_bg, e_ba;
        logic [16:0] e_addr;
        logic [63:0] e_dq, e_rd;
        logic [15:0] e_open;

        rst_in = 1'b1;
        dq_in  = '0;
        drive(0, 3'd0, 0, 8'h0, 4'h0, 64'h0);

        // Reset state
        @(negedge clk);
        chk("rst_act",   64'(act_out), 0);
        chk("rst_cmd",   64'(dram_cmd_out), 0);
        chk("rst_addr",  64'(dram_addr_out), 0);
        chk("rst_oe",    64'(dq_oe_out), 0);
        chk("rst_err",   64'(err_out), 0);
        chk("rst_rv",    64'(rdata_valid_out), 0);
        chk("rst_open",  64'(bank_open_out), 0);
        chk("rst_dq",    dq_out, 0);
        @(posedge clk); #1;
        rst_in = 1'b0;

        // Table: back-to-back cycles starting from reset
        tbl[0]  = mk(1, 3'd2,  1, 8'h12, 4'd0, 1, 1, 2'd0, 17'h12, 0);
        tbl[1]  = mk(1, 3'd0,  1, 8'h12, 4'd3, 0, 0, 2'd0, 17'h0,  0);
        tbl[2]  = mk(1, 3'd2,  1, 8'h12, 4'd0, 1, 0, 2'd0, 17'h0,  1);
        tbl[3]  = mk(1, 3'd3,  1, 8'h00, 4'd0, 0, 0, 2'd0, 17'h0,  0);
        tbl[4]  = mk(1, 3'd5,  1, 8'h00, 4'd0, 1, 0, 2'd0, 17'h0,  1);
        tbl[5]  = mk(1, 3'd3,  4, 8'h00, 4'd0, 1, 0, 2'd0, 17'h0,  0);
        tbl[6]  = mk(0, 3'd2,  9, 8'h00, 4'd0, 1, 0, 2'd0, 17'h0,  0);
        tbl[7]  = mk(1, 3'd0,  1, 8'h12, 4'd3, 0, 0, 2'd0, 17'h0,  0);
        tbl[8]  = mk(1, 3'd0,  1, 8'h12, 4'd3, 1, 0, 2'd1, 17'h3,  0);
        tbl[9]  = mk(1, 3'd0,  1, 8'h13, 4'd4, 1, 0, 2'd0, 17'h0,  1);
        tbl[10] = mk(1, 3'd1,  1, 8'h12, 4'd5, 0, 0, 2'd0, 17'h0,  0);
        tbl[11] = mk(1, 3'd2, 15, 8'hFF, 4'd0, 1, 1, 2'd0, 17'hFF, 0);
        tbl[12] = mk(1, 3'd3,  1, 8'h00, 4'd0, 1, 0, 2'd3, 17'h0,  0);
        tbl[13] = mk(1, 3'd0,  1, 8'h12, 4'd3, 1, 0, 2'd0, 17'h0,  1);
        tbl[14] = mk(1, 3'd2,  1, 8'h21, 4'd0, 0, 0, 2'd0, 17'h0,  0);
        tbl[15] = mk(0, 3'd2,  1, 8'h21, 4'd0, 0, 0, 2'd0, 17'h0,  0);
        tbl[16] = mk(1, 3'd2,  1, 8'h21, 4'd0, 0, 0, 2'd0, 17'h0,  0);
        tbl[17] = mk(1, 3'd2,  1, 8'h21, 4'd0, 1, 1, 2'd0, 17'h21, 0);

        for (int i = 0; i <= 18; i++) begin
            @(posedge clk); #1;
            if (i < 18) drive(tbl[i].v, tbl[i].cmd, tbl[i].bank, tbl[i].row, tbl[i].col, 64'h0);
            else idle();
            @(negedge clk);
            if (i < 18) chk($sformatf("tbl%0d_ready", i), 64'(cmd_ready_out), 64'(tbl[i].e_rdy));
            if (i > 0) begin
                chk($sformatf("tbl%0d_act", i - 1),  64'(act_out),       64'(tbl[i-1].e_act));
                chk($sformatf("tbl%0d_cmd", i - 1),  64'(dram_cmd_out),  64'(tbl[i-1].e_cmd));
                chk($sformatf("tbl%0d_addr", i - 1), 64'(dram_addr_out), 64'(tbl[i-1].e_addr));
                chk($sformatf("tbl%0d_err", i - 1),  64'(err_out),       64'(tbl[i-1].e_err));
            end
        end

        // ACT at 10, RD held from 11, data back at 42; then row-mismatch RD
        do_reset();
        acc = 0;
        for (int c = 0; c <= 45; c++) begin
            @(posedge clk); #1;
            if (c == 10)              drive(1, 3'd2, 0, 8'h12, 4'd0, 64'h0);
            else if (c >= 11 && !acc) drive(1, 3'd0, 0, 8'h12, 4'd3, 64'h0);
            else if (c == 44)         drive(1, 3'd0, 0, 8'h13, 4'd1, 64'h0);
            else                      idle();
            dq_in = (c == 41) ? 64'hDEADBEEF : 64'h0;
            @(negedge clk);
            if (c == 11) begin
                chk("s1_act", 64'(act_out), 1);
                chk("s1_act_addr", 64'(dram_addr_out), 64'h12);
            end
            if (c >= 11 && c <= 17) chk($sformatf("s1_stall_c%0d", c), 64'(cmd_ready_out), 0);
            if (c == 18) begin
                chk("s1_rd_accept", 64'(cmd_ready_out), 1);
                acc = 1;
            end
            if (c == 19) begin
                chk("s1_rd_cmd", 64'(dram_cmd_out), 1);
                chk("s1_rd_addr", 64'(dram_addr_out), 3);
            end
            if (c == 20) chk("s1_rd_nop", 64'(dram_cmd_out), 0);
            if (c == 41) chk("s1_rv_early", 64'(rdata_valid_out), 0);
            if (c == 42) begin
                chk("s1_rv", 64'(rdata_valid_out), 1);
                chk("s1_rdata", rdata_out, 64'hDEADBEEF);
            end
            if (c == 43) chk("s1_rv_pulse", 64'(rdata_valid_out), 0);
            if (c == 44) chk("s2_mismatch_ready", 64'(cmd_ready_out), 1);
            if (c == 45) begin
                chk("s2_err", 64'(err_out), 1);
                chk("s2_no_cmd", 64'(dram_cmd_out), 0);
                chk("s2_still_open", 64'(bank_open_out), 64'h1);
            end
        end

        // PRE open bank0, ACT bank0 stalls until 5; ACT idle bank5 goes straight through
        acc = 0;
        for (int c = 0; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 0)        drive(1, 3'd3, 0, 8'h00, 4'd0, 64'h0);
            else if (c == 6)   drive(1, 3'd2, 5, 8'h56, 4'd0, 64'h0);
            else if (!acc)     drive(1, 3'd2, 0, 8'h34, 4'd0, 64'h0);
            else               idle();
            @(negedge clk);
            if (c == 1) begin
                chk("s3_pre_cmd", 64'(dram_cmd_out), 3);
                chk("s3_pre_addr", 64'(dram_addr_out), 0);
            end
            if (c >= 1 && c <= 4) chk($sformatf("s3_stall_c%0d", c), 64'(cmd_ready_out), 0);
            if (c == 5) begin
                chk("s3_act_accept", 64'(cmd_ready_out), 1);
                acc = 1;
            end
            if (c == 6) begin
                chk("s3_act_pin", 64'(act_out), 1);
                chk("s3_act_row", 64'(dram_addr_out), 64'h34);
                chk("s3_b5_ready", 64'(cmd_ready_out), 1);
            end
            if (c == 7) begin
                chk("s3_b5_act", 64'(act_out), 1);
                chk("s3_b5_bg", 64'(bg_out), 1);
                chk("s3_b5_ba", 64'(ba_out), 1);
            end
        end

        // RD at 8, WR held from 9: stalled through the read's data cycle (32)
        do_reset();
        acc = 0;
        for (int c = 0; c <= 35; c++) begin
            @(posedge clk); #1;
            if (c == 0)              drive(1, 3'd2, 0, 8'h55, 4'd0, 64'h0);
            else if (c == 8)         drive(1, 3'd0, 0, 8'h55, 4'd7, 64'h0);
            else if (c >= 9 && !acc) drive(1, 3'd1, 0, 8'h55, 4'd9, 64'h1122334455667788);
            else                     idle();
            dq_in = 64'hCAFE;
            @(negedge clk);
            if (c == 8) chk("s4_rd_ready", 64'(cmd_ready_out), 1);
            if (c >= 9 && c <= 32) chk($sformatf("s4_wr_stall_c%0d", c), 64'(cmd_ready_out), 0);
            if (c == 32) begin
                chk("s4_rv", 64'(rdata_valid_out), 1);
                chk("s4_rdata", rdata_out, 64'hCAFE);
            end
            if (c == 33) begin
                chk("s4_wr_accept", 64'(cmd_ready_out), 1);
                acc = 1;
            end
            if (c == 34) begin
                chk("s4_wr_cmd", 64'(dram_cmd_out), 2);
                chk("s4_wr_addr", 64'(dram_addr_out), 9);
                chk("s4_wr_oe", 64'(dq_oe_out), 1);
                chk("s4_wr_dq", dq_out, 64'h1122334455667788);
            end
            if (c == 35) begin
                chk("s4_oe_drop", 64'(dq_oe_out), 0);
                chk("s4_dq_hold", dq_out, 64'h1122334455667788);
            end
        end

        // Reset 10 cycles after a RD: read discarded, banks closed, ACT accepted at once
        seen = 0;
        for (int c = 0; c <= 32; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive(1, 3'd0, 0, 8'h55, 4'd1, 64'h0);
            else if (c == 11) drive(1, 3'd2, 0, 8'h66, 4'd0, 64'h0);
            else idle();
            rst_in = (c == 10);
            @(negedge clk);
            if (c == 0) chk("s5_rd_ready", 64'(cmd_ready_out), 1);
            if (c == 11) begin
                chk("s5_open_cleared", 64'(bank_open_out), 0);
                chk("s5_act_ready", 64'(cmd_ready_out), 1);
            end
            if (c == 12) chk("s5_act_pin", 64'(act_out), 1);
            if (c >= 10 && rdata_valid_out) seen = 1;
        end
        chk("s5_no_rdata", 64'(seen), 0);

        // Two banks interleaved: reads return in order at 32 and 33
        do_reset();
        for (int c = 0; c <= 34; c++) begin
            @(posedge clk); #1;
            case (c)
                0:       drive(1, 3'd2, 0, 8'h01, 4'd0, 64'h0);
                1:       drive(1, 3'd2, 5, 8'h02, 4'd0, 64'h0);
                8:       drive(1, 3'd0, 0, 8'h01, 4'd0, 64'h0);
                9:       drive(1, 3'd0, 5, 8'h02, 4'd0, 64'h0);
                default: idle();
            endcase
            dq_in = 64'hA000 + 64'(c);
            @(negedge clk);
            if (c == 0 || c == 1 || c == 8 || c == 9)
                chk($sformatf("s6_ready_c%0d", c), 64'(cmd_ready_out), 1);
            if (c == 31) chk("s6_rv_early", 64'(rdata_valid_out), 0);
            if (c == 32) begin
                chk("s6_rv0", 64'(rdata_valid_out), 1);
                chk("s6_rdata0", rdata_out, 64'hA01F);
            end
            if (c == 33) begin
                chk("s6_rv1", 64'(rdata_valid_out), 1);
                chk("s6_rdata1", rdata_out, 64'hA020);
            end
            if (c == 34) chk("s6_rv_end", 64'(rdata_valid_out), 0);
        end

        // Randomized run against the model
        do_reset();
        for (int b = 0; b < 16; b++) begin
            m_isact[b] = 0;
            m_t[b]     = -1000;
            m_row[b]   = '0;
        end
        rd_q.delete();
        e_act = 0; e_err = 0; e_oe = 0; e_cmd = 0; e_addr = 0;
        e_bg = 0; e_ba = 0; e_dq = 0;
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #1;
            v    = ($urandom_range(0, 9) < 8);
            r    = int'($urandom_range(0, 99));
            mc   = (r < 30) ? 3'd0 : (r < 50) ? 3'd1 : (r < 75) ? 3'd2 :
                   (r < 95) ? 3'd3 : 3'(4 + $urandom_range(0, 3));
            bank = 4 * int'($urandom_range(0, 1)) + int'($urandom_range(0, 1));
            row  = 8'($urandom_range(0, 1));
            col  = 4'($urandom);
            wd   = {$urandom, $urandom};
            drive(v, mc, bank, row, col, wd);
            dq_in = {$urandom, $urandom};
            dq_hist[c % 128] = dq_in;
            @(negedge clk);

            while (rd_q.size() > 0 && rd_q[0] + CL + 2 < c) void'(rd_q.pop_front());
            e_rv = (rd_q.size() > 0) && (rd_q[0] + CL + 2 == c);
            e_rd = dq_hist[(c + 127) % 128];
            infl = (rd_q.size() > 0);
            st   = bstate(bank, c);
            case (mc)
                3'd0:    mrdy = (st != 1);
                3'd1:    mrdy = (st != 1) && !infl;
                3'd2:    mrdy = (st != 3);
                3'd3:    mrdy = (st != 1);
                default: mrdy = 1;
            endcase
            for (int b = 0; b < 16; b++) e_open[b] = (bstate(b, c) == 2);

            chk("rnd_ready", 64'(cmd_ready_out), 64'(mrdy));
            chk("rnd_act",   64'(act_out), 64'(e_act));
            chk("rnd_cmd",   64'(dram_cmd_out), 64'(e_cmd));
            chk("rnd_addr",  64'(dram_addr_out), 64'(e_addr));
            chk("rnd_err",   64'(err_out), 64'(e_err));
            chk("rnd_oe",    64'(dq_oe_out), 64'(e_oe));
            chk("rnd_bgba",  64'({bg_out, ba_out}), 64'({e_bg, e_ba}));
            chk("rnd_dq",    dq_out, e_dq);
            chk("rnd_rv",    64'(rdata_valid_out), 64'(e_rv));
            if (e_rv) chk("rnd_rdata", rdata_out, e_rd);
            chk("rnd_open",  64'(bank_open_out), 64'(e_open));

            e_act = 0; e_err = 0; e_oe = 0; e_cmd = 0; e_addr = 0;
            if (v && mrdy) begin
                case (mc)
                    3'd0, 3'd1: begin
                        if (st == 2 && row == m_row[bank]) begin
                            e_cmd  = (mc == 3'd0) ? 2'd1 : 2'd2;
                            e_addr = 17'(col);
                            e_bg   = 2'(bank / 4);
                            e_ba   = 2'(bank % 4);
                            if (mc == 3'd1) begin
                                e_oe = 1;
                                e_dq = wd;
                            end else begin
                                rd_q.push_back(c);
                            end
                        end else begin
                            e_err = 1;
                        end
                    end
                    3'd2: begin
                        if (st == 0) begin
                            e_act = 1;
                            e_addr = 17'(row);
                            e_bg = 2'(bank / 4);
                            e_ba = 2'(bank % 4);
                            m_isact[bank] = 1;
                            m_t[bank] = c;
                            m_row[bank] = row;
                        end else begin
                            e_err = 1;
                        end
                    end
                    3'd3: begin
                        if (st == 2) begin
                            e_cmd = 2'd3;
                            e_bg = 2'(bank / 4);
                            e_ba = 2'(bank % 4);
                            m_isact[bank] = 0;
                            m_t[bank] = c;
                        end
                    end
                    default: e_err = 1;
                endcase
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
